// File: rtl/msg_tx_queue.sv
// msg_tx_queue: DEPTH-entry message FIFO between the keypad controller and a
// UART transmitter. Letters arrive as single-cycle ready/data pulses. They
// leave one at a time through the transmit_ready / tx_ctrl / tx_byte
// handshake. With BATCH=1, only entries released by commit are sent.
//
// Ports
//   clk            system clock, rising edge
//   nRst           asynchronous active-low reset
//   ready, data    enqueue pulse and message
//   commit         release the current contents for sending (BATCH=1 only)
//   clear          flush the queue and clear overflow
//   transmit_ready UART idle / accept indicator
//   tx_ctrl        one-cycle start pulse to the UART
//   tx_byte        byte being sent, held until the next tx_ctrl
//   blue           high while entries are queued or a send is in flight
//   full           occupancy == DEPTH
//   overflow       sticky, set when a write was dropped
//   count          current occupancy

module msg_tx_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter bit BATCH = 1'b0
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic                       ready,
    input  logic [WIDTH-1:0]           data,
    input  logic                       commit,
    input  logic                       clear,
    input  logic                       transmit_ready,
    output logic                       tx_ctrl,
    output logic [WIDTH-1:0]           tx_byte,
    output logic                       blue,
    output logic                       full,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    // state   | meaning
    // IDLE    | waiting for a sendable entry and an idle UART
    // SEND    | tx_ctrl high for one cycle, head entry popped
    // WAIT_LO | waiting for the UART to drop transmit_ready
    // WAIT_HI | waiting for the UART to raise transmit_ready again

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_LO, WAIT_HI} state_t;

    state_t           state_q;
    logic             tx_ctrl_q;
    logic [WIDTH-1:0] tx_byte_q;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] budget_q, budget_d;
    logic             overflow_q, overflow_d;

    logic             pop;
    logic             push;
    logic             drop;
    logic [CNT_W-1:0] budget_eff;

    // A clear landing on the IDLE->SEND edge empties the queue before the
    // SEND cycle, so the pop is qualified by a non-empty count.
    assign pop  = (state_q == SEND) && (count_q != '0);
    assign push = ready && !clear && ((count_q != CNT_MAX) || pop);
    assign drop = ready && !clear && !push;

    // Streaming mode sends whatever is queued.
    assign budget_eff = BATCH ? budget_q : count_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        budget_d   = budget_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            budget_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
            // commit sees the occupancy after this cycle's write and pop
            if (BATCH && commit) begin
                budget_d = count_d;
            end else if (pop && (budget_q != '0)) begin
                budget_d = budget_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            budget_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            budget_q   <= budget_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // tx_byte is loaded on the edge entering SEND so it is valid together
    // with tx_ctrl; the head is popped on the edge leaving SEND.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            tx_ctrl_q <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            tx_ctrl_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((count_q != '0) && (budget_eff != '0) && transmit_ready) begin
                        state_q   <= SEND;
                        tx_ctrl_q <= 1'b1;
                        tx_byte_q <= mem_q[rd_ptr_q];
                    end
                end
                SEND: begin
                    state_q <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!transmit_ready) begin
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (transmit_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ctrl  = tx_ctrl_q;
    assign tx_byte  = tx_byte_q;
    assign overflow = overflow_q;
    assign count    = count_q;
    assign full     = (count_q == CNT_MAX);
    assign blue     = (count_q != '0) || (state_q != IDLE);

endmodule

// File: doc/msg_tx_queue.md
# msg_tx_queue

Parametrised successor to the player-side message register. Buffers letters from the keypad controller (`ready`/`data`) in a DEPTH-entry FIFO and hands them one at a time to the UART transmitter through the `transmit_ready`/`tx_ctrl`/`tx_byte` handshake. It adds two things the single-entry register lacks:

- **Batch mode:** letters are held until an explicit `commit`.
- **Status outputs:** occupancy, overflow and flush.

It sits between `keypad_controller_player` and the UART TX on the player side, and is equally usable on the host side.

## Interface
- `WIDTH`, default 8: message width in bits (ASCII letter).
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2.
- `BATCH`, default 0: send mode.
  - 0: stream; any queued entry is sent as soon as the UART is idle.
  - 1: batch; entries are sent only after `commit`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `nRst`  in  1  reset, asynchronous and active-low.
- `ready`  in  1  one-cycle pulse; `data` is valid this cycle.
- `data`  in  WIDTH  message to enqueue.
- `commit`  in  1  one-cycle pulse; releases the current contents for sending. Ignored when BATCH=0.
- `clear`  in  1  one-cycle pulse; flushes the queue and clears `overflow`.
- `transmit_ready`  in  1  UART TX is idle and can accept a byte.
- `tx_ctrl`  out  1  one-cycle start pulse to the UART.
- `tx_byte`  out  WIDTH  byte to send. Registered and held until the next `tx_ctrl`.
- `blue`  out  1  status LED; high while count ≠ 0 or a send is in flight.
- `full`  out  1  count == DEPTH.
- `overflow`  out  1  sticky; a write was dropped.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- **Storage:** circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `count` is a separate register of $clog2(DEPTH+1) bits.

- **Write:** on `ready`, `data` is stored at the write pointer and count increments, provided count < DEPTH or a pop occurs in the same cycle.
  - Otherwise the write is dropped and `overflow` is set.

- **Budget (BATCH=1):** `commit` loads `budget` ← count (post-write value if `ready` coincides).
  - Each pop decrements `budget`.
  - A `commit` during a drain reloads `budget` with the current count.
  - Entries written after a commit are not sent until the next `commit`.
  - With BATCH=0, `budget` is treated as always equal to count.

- **TX FSM**, states IDLE, SEND, WAIT_LO, WAIT_HI:
  - **IDLE → SEND** when count ≠ 0, budget ≠ 0 and `transmit_ready`=1.
  - **SEND:** one cycle. `tx_ctrl`=1, `tx_byte` ← head entry, pop (read pointer +1, count −1, budget −1). Then → WAIT_LO.
  - **WAIT_LO:** wait for `transmit_ready`=0 (UART accepted the byte), then → WAIT_HI.
  - **WAIT_HI:** wait for `transmit_ready`=1, then → IDLE.

- **Clear:**
  - Pointers, count, budget and `overflow` go to 0.
  - The FSM is not aborted: an in-flight send completes its handshake, and `tx_byte` holds its value.

- **Priority:** `clear` beats a same-cycle `ready` (the data is dropped, `overflow` is not set) and beats a same-cycle `commit`.
  - A SEND in the same cycle as `clear` still issues `tx_ctrl`; the pop is subsumed by the flush.

- **Simultaneous write and pop:** both occur and count is unchanged. A write is accepted even when `full`=1 if a pop occurs in the same cycle.

## Timing
- **Reset values (async, nRst=0):** state IDLE; pointers, count, budget = 0; `tx_ctrl`=0, `tx_byte`=0, `blue`=0, `full`=0, `overflow`=0, `count`=0.
- **Latency:** a `ready` at edge N updates count at N+1. With BATCH=0 and the UART idle, `tx_ctrl` is high in cycle N+2, with `tx_byte` valid the same cycle.
- **Pacing:**
  - `tx_ctrl` is never high in two consecutive cycles.
  - Minimum spacing between sends is 4 cycles (SEND, WAIT_LO, WAIT_HI, IDLE).
- **Combinational outputs:** `full`, `count` and `blue` are decoded from registers. There is no combinational path from inputs to outputs.
- **Stalled UART:** if `transmit_ready` never drops, the FSM waits indefinitely in WAIT_LO. Recovery is by reset only.

## Test plan
- **Reset:** hold nRst=0 mid-transfer → all outputs at their reset values on the next sample, asynchronously (no clock edge needed).
- **Stream:** BATCH=0, `transmit_ready`=1, `ready` with `data`=8'h41 → `tx_ctrl` pulses 2 cycles later with `tx_byte`=8'h41. After the UART toggles `transmit_ready` 1→0→1, `blue`=0 and `count`=0.
- **Overflow:** BATCH=0, UART held busy (`transmit_ready`=0), write 'A','B','C','D','E' → count=4, `full`=1, `overflow`=1. After release, exactly A,B,C,D are sent in order.
- **Batch:** BATCH=1, write 'H','I' then `commit`, then write 'X' → only 'H','I' are sent; count=1. A second `commit` sends 'X'.
- **Clear mid-drain:** 3 entries queued, `clear` in the SEND cycle of the first → the first byte's handshake completes, then no further `tx_ctrl`; count=0, `overflow`=0.
- **Write and pop at full:** full queue, `ready` in the SEND cycle → write accepted, count stays 4, the new byte is sent last.
